// File: rtl/uart_frame_parser.sv
// Frame parser behind the UART receiver: HEADER, LEN, payload, CHK.
// Checked payloads are buffered and replayed on a valid/ready byte stream.
module uart_frame_parser #(
  parameter logic [7:0]  HEADER  = 8'hA5,
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned TMO_CYC = 50000
) (
  input  logic       sclk_50M,
  input  logic       s_rst_n,
  input  logic [7:0] rx_data,
  input  logic       done_flag,
  output logic [7:0] pay_data,
  output logic       pay_valid,
  output logic       pay_last,
  input  logic       pay_ready,
  output logic       frame_ok,
  output logic       err_len,
  output logic       err_chk,
  output logic       err_tmo,
  output logic       rx_drop,
  output logic       busy
);

  localparam int unsigned IDX_W = $clog2(MAX_LEN + 1);
  localparam int unsigned AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned CNT_W = $clog2(TMO_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CHK,
    S_SEND
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] len_q, len_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       sum_q, sum_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic [7:0]       pay_data_q, pay_data_d;
  logic             pay_last_q, pay_last_d;
  logic             frame_ok_q, frame_ok_d;
  logic             err_len_q, err_len_d;
  logic             err_chk_q, err_chk_d;
  logic             err_tmo_q, err_tmo_d;
  logic             rx_drop_q, rx_drop_d;
  logic             buf_we;
  logic [7:0]       buf_q [MAX_LEN];

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    sum_d      = sum_q;
    tmo_d      = '0;
    pay_data_d = pay_data_q;
    pay_last_d = pay_last_q;
    frame_ok_d = 1'b0;
    err_len_d  = 1'b0;
    err_chk_d  = 1'b0;
    err_tmo_d  = 1'b0;
    rx_drop_d  = 1'b0;
    buf_we     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (done_flag && (rx_data == HEADER)) state_d = S_LEN;
      end

      S_LEN, S_DATA, S_CHK: begin
        // A byte on the terminal-count cycle takes priority over the timeout.
        if (done_flag) begin
          if (state_q == S_LEN) begin
            if ((rx_data == '0) || (32'(rx_data) > MAX_LEN)) begin
              err_len_d = 1'b1;
              state_d   = S_IDLE;
            end else begin
              len_d   = rx_data[IDX_W-1:0];
              sum_d   = rx_data;
              idx_d   = '0;
              state_d = S_DATA;
            end
          end else if (state_q == S_DATA) begin
            buf_we = 1'b1;
            sum_d  = sum_q + rx_data;
            if (idx_q == len_q - 1'b1) state_d = S_CHK;
            else                       idx_d   = idx_q + 1'b1;
          end else begin
            if (rx_data == sum_q) begin
              frame_ok_d = 1'b1;
              idx_d      = '0;
              pay_data_d = buf_q[0];
              pay_last_d = (len_q == IDX_W'(1));
              state_d    = S_SEND;
            end else begin
              err_chk_d = 1'b1;
              state_d   = S_IDLE;
            end
          end
        end else if (tmo_q == CNT_W'(TMO_CYC - 1)) begin
          err_tmo_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      S_SEND: begin
        // idx doubles as the read pointer once the payload is captured.
        rx_drop_d = done_flag;
        if (pay_ready) begin
          if (pay_last_q) begin
            pay_last_d = 1'b0;
            state_d    = S_IDLE;
          end else begin
            idx_d      = idx_q + 1'b1;
            pay_data_d = buf_q[idx_d[AW-1:0]];
            pay_last_d = (idx_d == len_q - 1'b1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sclk_50M or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      sum_q      <= '0;
      tmo_q      <= '0;
      pay_data_q <= '0;
      pay_last_q <= 1'b0;
      frame_ok_q <= 1'b0;
      err_len_q  <= 1'b0;
      err_chk_q  <= 1'b0;
      err_tmo_q  <= 1'b0;
      rx_drop_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      sum_q      <= sum_d;
      tmo_q      <= tmo_d;
      pay_data_q <= pay_data_d;
      pay_last_q <= pay_last_d;
      frame_ok_q <= frame_ok_d;
      err_len_q  <= err_len_d;
      err_chk_q  <= err_chk_d;
      err_tmo_q  <= err_tmo_d;
      rx_drop_q  <= rx_drop_d;
    end
  end

  // Payload storage is deliberately unreset; only written entries are ever read.
  always_ff @(posedge sclk_50M) begin
    if (buf_we) buf_q[idx_q[AW-1:0]] <= rx_data;
  end

  assign pay_data  = pay_data_q;
  assign pay_valid = (state_q == S_SEND);
  assign pay_last  = pay_last_q;
  assign frame_ok  = frame_ok_q;
  assign err_len   = err_len_q;
  assign err_chk   = err_chk_q;
  assign err_tmo   = err_tmo_q;
  assign rx_drop   = rx_drop_q;
  assign busy      = (state_q != S_IDLE);

endmodule
